point_sequencer: RTL
====================

Name: point_sequencer

Overview:
- Parametrised frame-to-vector sequencer between the point frame buffer (UART receive side) and the line-draw/DAC controller.
- Walks a completed frame of packed point words and issues one draw or jump command per point over the drawer's ready handshake.
- Drives a multi-channel beam intensity bus and signals frame completion back to the buffer.
- Generalises the single on/off beam to CHANNELS x INTENSITY_W intensity, with explicit jump (blanked move) commands.

Parameters:
- COORD_W, 12, width of each X/Y coordinate.
- ADDR_W, 11, frame buffer address width; maximum frame length is 2^ADDR_W points.
- CHANNELS, 3, number of beam intensity channels (e.g. R,G,B).
- INTENSITY_W, 4, bits per channel.
- DWELL_CYCLES, 16, blanked settle cycles after a jump; used only with BLANK_DWELL_EN, minimum 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_valid  in  1  buffer holds a complete frame.
- num_points  in  ADDR_W+1  point count of the frame, 0..2^ADDR_W.
- rd_addr  out  ADDR_W  buffer read address, registered.
- rd_data  in  1+CHANNELS*INTENSITY_W+2*COORD_W  point word; valid 1 cycle after rd_addr changes. Layout MSB..LSB is {jump, intensity, x, y}.
- frame_done  out  1  one-cycle pulse when the frame is finished.
- ready  in  1  drawer can accept a command.
- draw  out  1  one-cycle pulse: beam-on line to x,y.
- jump  out  1  one-cycle pulse: blanked move to x,y.
- x  out  COORD_W  target X, held until the next command.
- y  out  COORD_W  target Y, held until the next command.
- beam  out  CHANNELS*INTENSITY_W  current beam intensity.
- busy  out  1  high whenever not in IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs 0. State IDLE, point index 0, internal count 0.
- IDLE:
  - frame_valid=1: latch num_points into count, rd_addr<=0.
    - count=0: go DONE.
    - Otherwise: go READ.
  - frame_valid is ignored in the first IDLE cycle after DONE. The buffer must drop frame_valid within 1 cycle of frame_done.
- READ: one cycle for the RAM read; go ISSUE.
- ISSUE: capture rd_data into the point register, then wait for ready=1. On the cycle ready=1:
  - Update x, y from the point.
  - jump bit=1: jump<=1, beam<=0.
  - jump bit=0: draw<=1, beam<=intensity field.
  - Go HOLD.
  - x, y and beam change only in this cycle, so they are coincident with the pulse.
- HOLD: one cycle; draw/jump return to 0; ready is ignored so a command is never double-issued.
  - index+1=count: go DONE.
  - Otherwise: index++, rd_addr++, go READ.
- DONE: frame_done<=1 for one cycle, beam<=0, index<=0; go IDLE. x and y keep their last values.
- Timing:
  - With ready tied high, each point takes exactly 3 cycles (READ, ISSUE, HOLD).
  - A frame of N points runs 1 (IDLE) + 3N + 1 (DONE) cycles from frame_valid sampled to the frame_done pulse.
- frame_valid or num_points changing mid-frame: ignored; the latched count governs.
- Full frame (num_points=2^ADDR_W): rd_addr reaches 2^ADDR_W-1 with no wrap; then DONE.
- ready stuck low: stays in ISSUE indefinitely with outputs stable; no timeout.
- reset_n low mid-frame: immediate return to reset state with beam=0. No frame_done pulse is issued.
- draw and jump are never high together and never high in consecutive cycles.

Optional Feature:
- Macro BLANK_DWELL_EN.
- Defined: a HOLD that follows a jump command is extended to DWELL_CYCLES cycles via a down-counter, with beam held 0, before the next READ or DONE. HOLD after a draw remains 1 cycle.
- Undefined: no dwell counter; HOLD is always 1 cycle and DWELL_CYCLES is ignored.

Test Plan:
- Reset: assert reset_n=0 mid-stream with draw pending -> all outputs 0 asynchronously; after release, busy=0 and no draw/jump until frame_valid.
- Frame of 3 points {jump,(100,200)}, {draw, I=0xF0A,(300,400)}, {draw, I=0x00F,(5,6)}, ready=1 -> jump, draw, draw pulses exactly 3 cycles apart. beam=0, then 0xF0A, then 0x00F, each coincident with its pulse. frame_done 11 cycles after frame_valid sampled, then beam=0.
- ready low for 20 cycles in ISSUE -> no pulse, rd_addr stable. Pulse in the cycle ready rises; single pulse even if ready stays high.
- num_points=0 with frame_valid=1 -> frame_done after 2 cycles, no draw/jump, rd_addr=0.
- num_points=2048 (ADDR_W=11) -> 2048 commands, last rd_addr=2047, then frame_done; frame_valid held high afterwards causes no restart in the first IDLE cycle.
- BLANK_DWELL_EN defined, DWELL_CYCLES=16, points jump then draw -> draw pulse 18 cycles after jump pulse, beam=0 throughout; undefined -> 3 cycles.

Source files
------------

// File: rtl/point_sequencer.sv
// Frame-to-vector sequencer: walks a buffered frame of packed point words and issues one
// draw or jump command per point to the line drawer. Macro BLANK_DWELL_EN adds post-jump dwell.
module point_sequencer #(
  parameter int unsigned COORD_W      = 12,
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned INTENSITY_W  = 4,
  parameter int unsigned DWELL_CYCLES = 16
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          frame_valid,
  input  logic [ADDR_W:0]                               num_points,
  output logic [ADDR_W-1:0]                             rd_addr,
  input  logic [1+CHANNELS*INTENSITY_W+2*COORD_W-1:0]   rd_data,
  output logic                                          frame_done,
  input  logic                                          ready,
  output logic                                          draw,
  output logic                                          jump,
  output logic [COORD_W-1:0]                            x,
  output logic [COORD_W-1:0]                            y,
  output logic [CHANNELS*INTENSITY_W-1:0]               beam,
  output logic                                          busy
);

  localparam int unsigned BeamW  = CHANNELS * INTENSITY_W;
  localparam int unsigned PointW = 1 + BeamW + 2 * COORD_W;

  if (DWELL_CYCLES == 0) begin : g_dwell_check
    $error("DWELL_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StRead, StIssue, StHold, StDone} state_e;

  state_e              state_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     index_q;
  logic [ADDR_W:0]     index_next;
  logic [PointW-1:0]   point_q;
  logic                fresh_q;
  logic [PointW-1:0]   point;
  logic                pt_jump;
  logic [BeamW-1:0]    pt_beam;
  logic [COORD_W-1:0]  pt_x;
  logic [COORD_W-1:0]  pt_y;
  logic                hold_done;

  // On the first ISSUE cycle the RAM output is used directly; later cycles use the capture.
  assign point      = fresh_q ? rd_data : point_q;
  assign pt_jump    = point[PointW-1];
  assign pt_beam    = point[2*COORD_W +: BeamW];
  assign pt_x       = point[COORD_W +: COORD_W];
  assign pt_y       = point[0 +: COORD_W];
  assign index_next = index_q + (ADDR_W+1)'(1);
  assign busy       = (state_q != StIdle);

`ifdef BLANK_DWELL_EN
  localparam int unsigned DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  logic [DwellW-1:0] dwell_q;
  assign hold_done = (dwell_q == '0);
`else
  assign hold_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      index_q    <= '0;
      point_q    <= '0;
      fresh_q    <= 1'b0;
      rd_addr    <= '0;
      frame_done <= 1'b0;
      draw       <= 1'b0;
      jump       <= 1'b0;
      x          <= '0;
      y          <= '0;
      beam       <= '0;
`ifdef BLANK_DWELL_EN
      dwell_q    <= '0;
`endif
    end else begin
      draw       <= 1'b0;
      jump       <= 1'b0;
      frame_done <= 1'b0;
      case (state_q)
        StIdle: begin
          // frame_done still high marks the first IDLE cycle, where frame_valid is stale.
          if (frame_valid && !frame_done) begin
            count_q <= num_points;
            index_q <= '0;
            rd_addr <= '0;
            state_q <= (num_points == '0) ? StDone : StRead;
          end
        end
        StRead: begin
          fresh_q <= 1'b1;
          state_q <= StIssue;
        end
        StIssue: begin
          fresh_q <= 1'b0;
          if (fresh_q) point_q <= rd_data;
          if (ready) begin
            x <= pt_x;
            y <= pt_y;
            if (pt_jump) begin
              jump <= 1'b1;
              beam <= '0;
            end else begin
              draw <= 1'b1;
              beam <= pt_beam;
            end
`ifdef BLANK_DWELL_EN
            dwell_q <= pt_jump ? DwellW'(DWELL_CYCLES - 1) : '0;
`endif
            state_q <= StHold;
          end
        end
        StHold: begin
`ifdef BLANK_DWELL_EN
          if (!hold_done) dwell_q <= dwell_q - DwellW'(1);
`endif
          if (hold_done) begin
            if (index_next == count_q) begin
              state_q <= StDone;
            end else begin
              index_q <= index_next;
              rd_addr <= rd_addr + ADDR_W'(1);
              state_q <= StRead;
            end
          end
        end
        StDone: begin
          frame_done <= 1'b1;
          beam       <= '0;
          index_q    <= '0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
